t04_mem_access_unit: RTL and testbench
======================================

Name: t04_mem_access_unit

Overview:
- Parametrised successor to the word-only, single-request fetch/load-store handshake in the t04 datapath.
- Arbitrates instruction fetch and data requests onto one shared memory bus.
- Adds byte and halfword accesses with lane steering, sign and zero extension, misalignment detection, and a registered response stage.
- Generates Freeze for the core and sits between t04_datapath and the bus wrapper.

Parameters:
- XLEN, 32, data and address width. Only 32 is supported; elaboration fails otherwise.
- TIMEOUT, 255, maximum wait cycles for an ack. Used only with T04_MAU_TIMEOUT_EN.
- NOP_INSTR, 32'h00000013, instruction returned on a fetch bus error.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  core requests fetch at pc
- pc  in  XLEN  fetch address (word aligned)
- d_read  in  1  core requests load
- d_write  in  1  core requests store
- d_funct3  in  3  RV32 load/store funct3
- d_addr  in  XLEN  data byte address
- d_wdata  in  XLEN  store data, right-aligned
- i_ack  in  1  bus fetch done
- d_ack  in  1  bus data done
- instruction  in  32  fetched word from bus
- memload  in  XLEN  loaded word from bus
- final_address  out  XLEN  bus word address (bits [1:0] = 0)
- mem_store  out  XLEN  lane-steered store data
- mem_sel  out  4  byte enables
- mem_read  out  1  bus read strobe
- mem_write  out  1  bus write strobe
- instr_out  out  32  latched instruction
- load_data  out  XLEN  extended load result
- Freeze  out  1  core stall
- misaligned  out  1  one-cycle fault pulse
- bus_error  out  1  one-cycle timeout pulse

Behaviour:
- Reset (asynchronous, immediate): state IDLE; every output 0 except instr_out = NOP_INSTR; timeout counter cleared. A reset during a wait drops the bus strobes at once, and no response is produced.
- States: IDLE, I_WAIT, D_WAIT, RESP.
- IDLE priority: data first, then fetch. The data request belongs to the instruction already held in instr_out.
  - d_read or d_write with a legal, aligned access: latch the address, sel, store data and funct3; go to D_WAIT.
  - else i_req: latch pc; go to I_WAIT.
  - else stay in IDLE.
  - If d_read and d_write are both high, treat the request as a write.
- Legal funct3 values:
  - Load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store: 000 SB, 001 SH, 010 SW.
  - Any other funct3 counts as a fault.
- Alignment: H needs d_addr[0]=0; W needs d_addr[1:0]=0.
- Fault (misaligned or illegal funct3): misaligned pulses for the request cycle, no bus transaction, and go to RESP with load_data = 0 and no store issued.
- mem_sel:
  - B: 1 << addr[1:0].
  - H: 0011 << addr[1:0].
  - W: 1111.
- mem_store: d_wdata shifted left by 8*addr[1:0] (B and H replicate into the selected lane). Unselected lanes are don't-care, driven 0.
- Bus outputs are driven only in the WAIT states, from the latched registers:
  - I_WAIT: mem_read=1, mem_sel=1111.
  - D_WAIT: mem_read or mem_write as latched.
  - IDLE and RESP: all bus outputs 0.
- I_WAIT: on i_ack, instr_out <= instruction, then go to RESP. d_ack is ignored.
- D_WAIT: on d_ack:
  - For a load, load_data <= the selected byte or half, shifted down and sign- or zero-extended per funct3.
  - For a store, load_data is left unchanged.
  - Then go to RESP. i_ack is ignored.
- RESP: lasts one cycle. Outputs are valid, and the core advances at the closing edge. Requests are ignored. Then go to IDLE.
- Freeze = (IDLE and any request) or I_WAIT or D_WAIT. Freeze is 0 in RESP and in IDLE with no request.
- Minimum latency is 3 cycles: request, ack in WAIT, RESP. Each extra wait cycle adds one.
- Acks seen in IDLE or RESP are ignored.

Optional Feature:
- Macro: T04_MAU_TIMEOUT_EN.
- When defined:
  - An 8-bit counter, cleared on entry to a WAIT state, increments each WAIT cycle without the matching ack.
  - When it reaches TIMEOUT: bus_error pulses for one cycle, the strobes drop, and the unit goes to RESP with instr_out = NOP_INSTR (fetch) or load_data = 0 (load).
- When undefined: the unit waits indefinitely, and bus_error is tied to 0.

Test Plan:
- Fetch, i_ack after 2 wait cycles, instruction 32'h00828667 -> Freeze high for 3 cycles then low in RESP; instr_out = 32'h00828667; mem_sel = 1111.
- LB at d_addr=0x103, memload=32'h80FF_1234 -> mem_sel = 1000; load_data = 32'hFFFFFF80. LBU with the same inputs -> 32'h00000080.
- SH at d_addr=0x102, d_wdata=32'h0000ABCD -> final_address = 0x100, mem_sel = 1100, mem_store[31:16] = 16'hABCD, mem_write=1 only in D_WAIT.
- LW at d_addr=0x102 -> misaligned pulses one cycle; mem_read and mem_write stay 0; load_data = 0; back to IDLE after RESP.
- d_read and i_req together in IDLE -> the data access is issued first; the fetch follows after RESP. Asserting rst mid-D_WAIT drops mem_read in the same cycle and returns the unit to IDLE.
- With T04_MAU_TIMEOUT_EN and TIMEOUT=4, a fetch with no ack -> bus_error pulses at the 4th wait cycle; instr_out = 32'h00000013.

Source files
------------

// File: rtl/t04_mau_if.sv
// Core/bus handshake bundle for t04_mem_access_unit.
// The unit binds to the slave modport; the core/bus side uses master.
interface t04_mau_if #(
   parameter int XLEN = 32
);
   logic            i_req;
   logic [XLEN-1:0] pc;
   logic            d_read;
   logic            d_write;
   logic [2:0]      d_funct3;
   logic [XLEN-1:0] d_addr;
   logic [XLEN-1:0] d_wdata;
   logic            i_ack;
   logic            d_ack;
   logic [31:0]     instruction;
   logic [XLEN-1:0] memload;
   logic [XLEN-1:0] final_address;
   logic [XLEN-1:0] mem_store;
   logic [3:0]      mem_sel;
   logic            mem_read;
   logic            mem_write;
   logic [31:0]     instr_out;
   logic [XLEN-1:0] load_data;
   logic            Freeze;
   logic            misaligned;
   logic            bus_error;

   modport slave (
      input  i_req, pc, d_read, d_write, d_funct3, d_addr, d_wdata,
      input  i_ack, d_ack, instruction, memload,
      output final_address, mem_store, mem_sel, mem_read, mem_write,
      output instr_out, load_data, Freeze, misaligned, bus_error
   );

   modport master (
      output i_req, pc, d_read, d_write, d_funct3, d_addr, d_wdata,
      output i_ack, d_ack, instruction, memload,
      input  final_address, mem_store, mem_sel, mem_read, mem_write,
      input  instr_out, load_data, Freeze, misaligned, bus_error
   );
endinterface

// File: rtl/t04_mem_access_unit.sv
// Fetch/data arbiter onto one shared bus with byte/half lane steering and extension.
// Optional ack timeout enabled by defining T04_MAU_TIMEOUT_EN.
module t04_mem_access_unit #(
   parameter int          XLEN      = 32,
   parameter int          TIMEOUT   = 255,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input logic       clk,
   input logic       rst,
   t04_mau_if.slave  bus
);
   if (XLEN != 32) begin : g_xlen_check
      $error("t04_mem_access_unit supports only XLEN = 32");
   end
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_check
      $error("t04_mem_access_unit TIMEOUT must be 1..255");
   end

   typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT, RESP} state_t;

   state_t          state_q, state_d;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] load_q, load_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] store_q, store_d;
   logic [3:0]      sel_q, sel_d;
   logic [2:0]      f3_q, f3_d;
   logic            wr_q, wr_d;
   logic            d_req, fault;

   function automatic logic access_ok(input logic [2:0] f3, input logic wr,
                                      input logic [1:0] off);
      logic ok;
      case (f3)
         3'b000:  ok = 1'b1;
         3'b001:  ok = ~off[0];
         3'b010:  ok = (off == 2'b00);
         3'b100:  ok = ~wr;
         3'b101:  ok = ~wr & ~off[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] sel_of(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] s;
      case (f3[1:0])
         2'b00:   s = 4'b0001 << off;
         2'b01:   s = 4'b0011 << off;
         default: s = 4'b1111;
      endcase
      return s;
   endfunction

   function automatic logic [XLEN-1:0] steer_store(input logic [XLEN-1:0] wdata,
                                                   input logic [3:0] sel,
                                                   input logic [1:0] off);
      logic [XLEN-1:0] sh;
      logic [XLEN-1:0] r;
      sh = wdata << {off, 3'b000};
      for (int i = 0; i < 4; i++) begin
         r[8*i +: 8] = sel[i] ? sh[8*i +: 8] : 8'h00;
      end
      return r;
   endfunction

   function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] word,
                                                   input logic [2:0] f3,
                                                   input logic [1:0] off);
      logic [XLEN-1:0] sh;
      logic [XLEN-1:0] r;
      sh = word >> {off, 3'b000};
      case (f3)
         3'b000:  r = {{24{sh[7]}}, sh[7:0]};
         3'b001:  r = {{16{sh[15]}}, sh[15:0]};
         3'b100:  r = {24'h000000, sh[7:0]};
         3'b101:  r = {16'h0000, sh[15:0]};
         default: r = sh;
      endcase
      return r;
   endfunction

   assign d_req = bus.d_read | bus.d_write;
   assign fault = d_req & ~access_ok(bus.d_funct3, bus.d_write, bus.d_addr[1:0]);

`ifdef T04_MAU_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   logic       timeout_hit;
`endif

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      load_d  = load_q;
      addr_d  = addr_q;
      store_d = store_q;
      sel_d   = sel_q;
      f3_d    = f3_q;
      wr_d    = wr_q;
`ifdef T04_MAU_TIMEOUT_EN
      cnt_d       = cnt_q;
      timeout_hit = 1'b0;
`endif
      case (state_q)
         IDLE: begin
`ifdef T04_MAU_TIMEOUT_EN
            cnt_d = 8'd0;
`endif
            // Data wins: it belongs to the instruction already in instr_out.
            if (d_req) begin
               if (fault) begin
                  load_d  = '0;
                  state_d = RESP;
               end else begin
                  addr_d  = bus.d_addr;
                  sel_d   = sel_of(bus.d_funct3, bus.d_addr[1:0]);
                  store_d = bus.d_write ? steer_store(bus.d_wdata,
                               sel_of(bus.d_funct3, bus.d_addr[1:0]), bus.d_addr[1:0]) : '0;
                  f3_d    = bus.d_funct3;
                  wr_d    = bus.d_write;
                  state_d = D_WAIT;
               end
            end else if (bus.i_req) begin
               addr_d  = bus.pc;
               state_d = I_WAIT;
            end
         end
         I_WAIT: begin
            if (bus.i_ack) begin
               instr_d = bus.instruction;
               state_d = RESP;
            end
`ifdef T04_MAU_TIMEOUT_EN
            else if (cnt_q == 8'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               instr_d     = NOP_INSTR;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         D_WAIT: begin
            if (bus.d_ack) begin
               if (!wr_q) load_d = extend_load(bus.memload, f3_q, addr_q[1:0]);
               state_d = RESP;
            end
`ifdef T04_MAU_TIMEOUT_EN
            else if (cnt_q == 8'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               if (!wr_q) load_d = '0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         instr_q <= NOP_INSTR;
         load_q  <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         load_q  <= load_d;
      end
   end

   // Latched request fields only reach the bus through state gating, so no reset.
   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      store_q <= store_d;
      sel_q   <= sel_d;
      f3_q    <= f3_d;
      wr_q    <= wr_d;
   end

`ifdef T04_MAU_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= 8'd0;
      else     cnt_q <= cnt_d;
   end
   assign bus.bus_error = timeout_hit;
`else
   assign bus.bus_error = 1'b0;
`endif

   assign bus.mem_read      = (state_q == I_WAIT) | ((state_q == D_WAIT) & ~wr_q);
   assign bus.mem_write     = (state_q == D_WAIT) & wr_q;
   assign bus.mem_sel       = (state_q == I_WAIT) ? 4'b1111 :
                              (state_q == D_WAIT) ? sel_q : 4'b0000;
   assign bus.mem_store     = (state_q == D_WAIT) ? store_q : '0;
   assign bus.final_address = (state_q == I_WAIT || state_q == D_WAIT) ?
                              {addr_q[XLEN-1:2], 2'b00} : '0;
   assign bus.instr_out     = instr_q;
   assign bus.load_data     = load_q;
   assign bus.misaligned    = (state_q == IDLE) & fault;
   assign bus.Freeze        = ((state_q == IDLE) & (d_req | bus.i_req)) |
                              (state_q == I_WAIT) | (state_q == D_WAIT);
endmodule

// File: tb/tb_t04_mem_access_unit.sv
// Directed bench for t04_mem_access_unit: fetch, loads, stores, faults, arbitration, reset.
module tb_t04_mem_access_unit;
   logic clk = 1'b0;
   logic rst;
   int   total  = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   t04_mau_if #(.XLEN(32)) bus ();

   t04_mem_access_unit #(.XLEN(32), .TIMEOUT(4), .NOP_INSTR(32'h00000013)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clr_req();
      bus.i_req   = 1'b0;
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
   endtask

   task automatic req_data(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
      bus.d_read   = rd;
      bus.d_write  = wr;
      bus.d_funct3 = f3;
      bus.d_addr   = a;
      bus.d_wdata  = wd;
      #1;
   endtask

   // Ack in the current D_WAIT cycle, then sit in RESP sampled #1 later.
   task automatic ack_data(input logic [31:0] word);
      bus.d_ack   = 1'b1;
      bus.memload = word;
      tick();
      bus.d_ack = 1'b0;
      #1;
   endtask

   initial begin
      clr_req();
      bus.pc = '0; bus.d_funct3 = '0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.i_ack = 1'b0; bus.d_ack = 1'b0; bus.instruction = '0; bus.memload = '0;
      rst = 1'b0;
      #1 rst = 1'b1;
      #2;
      chk("rst_instr_out", bus.instr_out, 32'h00000013);
      chk("rst_load_data", bus.load_data, 32'h0);
      chk("rst_freeze", {31'b0, bus.Freeze}, 32'd0);
      chk("rst_mem_read", {31'b0, bus.mem_read}, 32'd0);
      chk("rst_mem_sel", {28'b0, bus.mem_sel}, 32'd0);
      chk("rst_final_addr", bus.final_address, 32'h0);
      @(posedge clk); #2 rst = 1'b0;
      tick();

      // Fetch with ack in the second wait cycle
      bus.i_req = 1'b1; bus.pc = 32'h0000_0200; #1;
      chk("fetch_freeze_req", {31'b0, bus.Freeze}, 32'd1);
      tick(); clr_req(); #1;
      chk("fetch_w1_freeze", {31'b0, bus.Freeze}, 32'd1);
      chk("fetch_w1_mem_read", {31'b0, bus.mem_read}, 32'd1);
      chk("fetch_w1_mem_sel", {28'b0, bus.mem_sel}, 32'hF);
      chk("fetch_w1_addr", bus.final_address, 32'h0000_0200);
      tick();
      bus.i_ack = 1'b1; bus.instruction = 32'h00828667; #1;
      chk("fetch_w2_freeze", {31'b0, bus.Freeze}, 32'd1);
      tick(); bus.i_ack = 1'b0; #1;
      chk("fetch_resp_freeze", {31'b0, bus.Freeze}, 32'd0);
      chk("fetch_resp_instr", bus.instr_out, 32'h00828667);
      chk("fetch_resp_mem_read", {31'b0, bus.mem_read}, 32'd0);
      tick();

      // LB / LBU at byte 3
      req_data(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
      chk("lb_misaligned", {31'b0, bus.misaligned}, 32'd0);
      tick(); clr_req(); #1;
      chk("lb_sel", {28'b0, bus.mem_sel}, 32'h8);
      chk("lb_addr", bus.final_address, 32'h0000_0100);
      chk("lb_mem_read", {31'b0, bus.mem_read}, 32'd1);
      ack_data(32'h80FF_1234);
      chk("lb_load", bus.load_data, 32'hFFFF_FF80);
      chk("lb_resp_freeze", {31'b0, bus.Freeze}, 32'd0);
      tick();
      req_data(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0);
      tick(); clr_req(); #1;
      ack_data(32'h80FF_1234);
      chk("lbu_load", bus.load_data, 32'h0000_0080);
      tick();

      // LH upper half, LHU lower half
      req_data(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0);
      tick(); clr_req(); #1;
      chk("lh_sel", {28'b0, bus.mem_sel}, 32'hC);
      ack_data(32'h8001_7FFF);
      chk("lh_load", bus.load_data, 32'hFFFF_8001);
      tick();
      req_data(1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0);
      tick(); clr_req(); #1;
      ack_data(32'h1234_F00D);
      chk("lhu_load", bus.load_data, 32'h0000_F00D);
      tick();

      // SH at 0x102
      req_data(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD);
      chk("sh_req_mem_write", {31'b0, bus.mem_write}, 32'd0);
      tick(); clr_req(); #1;
      chk("sh_addr", bus.final_address, 32'h0000_0100);
      chk("sh_sel", {28'b0, bus.mem_sel}, 32'hC);
      chk("sh_store", bus.mem_store, 32'hABCD_0000);
      chk("sh_mem_write", {31'b0, bus.mem_write}, 32'd1);
      chk("sh_mem_read", {31'b0, bus.mem_read}, 32'd0);
      ack_data(32'hFFFF_FFFF);
      chk("sh_resp_mem_write", {31'b0, bus.mem_write}, 32'd0);
      chk("sh_load_kept", bus.load_data, 32'h0000_F00D);
      tick();

      // SB lane 1 with dirty upper bits
      req_data(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'hFFFF_FF5A);
      tick(); clr_req(); #1;
      chk("sb_sel", {28'b0, bus.mem_sel}, 32'h2);
      chk("sb_store", bus.mem_store, 32'h0000_5A00);
      ack_data(32'h0);
      tick();

      // d_read and d_write together act as a SW
      req_data(1'b1, 1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF);
      tick(); clr_req(); #1;
      chk("rw_mem_write", {31'b0, bus.mem_write}, 32'd1);
      chk("rw_mem_read", {31'b0, bus.mem_read}, 32'd0);
      chk("sw_sel", {28'b0, bus.mem_sel}, 32'hF);
      chk("sw_store", bus.mem_store, 32'hDEAD_BEEF);
      ack_data(32'h0);
      tick();

      // Misaligned LW
      req_data(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0);
      chk("lw_mis_pulse", {31'b0, bus.misaligned}, 32'd1);
      chk("lw_mis_req_read", {31'b0, bus.mem_read}, 32'd0);
      tick(); clr_req(); #1;
      chk("lw_mis_resp_pulse", {31'b0, bus.misaligned}, 32'd0);
      chk("lw_mis_resp_read", {31'b0, bus.mem_read}, 32'd0);
      chk("lw_mis_resp_write", {31'b0, bus.mem_write}, 32'd0);
      chk("lw_mis_load", bus.load_data, 32'h0);
      chk("lw_mis_resp_freeze", {31'b0, bus.Freeze}, 32'd0);
      tick(); #1;
      chk("lw_mis_idle_freeze", {31'b0, bus.Freeze}, 32'd0);

      // Illegal store funct3 and misaligned LH
      req_data(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0);
      chk("ill_store_fault", {31'b0, bus.misaligned}, 32'd1);
      tick(); clr_req(); #1;
      chk("ill_store_no_write", {31'b0, bus.mem_write}, 32'd0);
      tick();
      req_data(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0);
      chk("lh_odd_fault", {31'b0, bus.misaligned}, 32'd1);
      tick(); clr_req(); #1;
      tick();

      // Data and fetch together: data first, fetch after RESP
      req_data(1'b1, 1'b0, 3'b010, 32'h0000_0108, 32'h0);
      bus.i_req = 1'b1; bus.pc = 32'h0000_0300; #1;
      tick(); bus.d_read = 1'b0; #1;
      chk("arb_data_first_addr", bus.final_address, 32'h0000_0108);
      ack_data(32'h1122_3344);
      chk("arb_lw_load", bus.load_data, 32'h1122_3344);
      chk("arb_resp_freeze", {31'b0, bus.Freeze}, 32'd0);
      tick(); #1;
      chk("arb_idle_freeze", {31'b0, bus.Freeze}, 32'd1);
      tick(); clr_req(); #1;
      chk("arb_fetch_addr", bus.final_address, 32'h0000_0300);
      bus.i_ack = 1'b1; bus.instruction = 32'h1234_5678;
      tick(); bus.i_ack = 1'b0; #1;
      chk("arb_fetch_instr", bus.instr_out, 32'h1234_5678);
      tick();

      // Fetch with no ack
      bus.i_req = 1'b1; bus.pc = 32'h0000_0400; #1;
      tick(); clr_req(); #1;
      chk("to_w1_bus_error", {31'b0, bus.bus_error}, 32'd0);
      tick(); tick(); #1;
      chk("to_w3_bus_error", {31'b0, bus.bus_error}, 32'd0);
      tick(); #1;
`ifdef T04_MAU_TIMEOUT_EN
      chk("to_w4_bus_error", {31'b0, bus.bus_error}, 32'd1);
      tick(); #1;
      chk("to_resp_bus_error", {31'b0, bus.bus_error}, 32'd0);
      chk("to_resp_mem_read", {31'b0, bus.mem_read}, 32'd0);
      chk("to_resp_instr", bus.instr_out, 32'h00000013);
      tick();
`else
      chk("to_w4_bus_error", {31'b0, bus.bus_error}, 32'd0);
      tick(); tick(); #1;
      chk("to_w6_mem_read", {31'b0, bus.mem_read}, 32'd1);
      bus.i_ack = 1'b1; bus.instruction = 32'hCAFE_F00D;
      tick(); bus.i_ack = 1'b0; #1;
      chk("to_late_instr", bus.instr_out, 32'hCAFE_F00D);
      tick();
`endif

      // Reset in the middle of D_WAIT
      req_data(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0);
      tick(); clr_req(); #1;
      chk("rstmid_mem_read_before", {31'b0, bus.mem_read}, 32'd1);
      rst = 1'b1; #1;
      chk("rstmid_mem_read", {31'b0, bus.mem_read}, 32'd0);
      chk("rstmid_freeze", {31'b0, bus.Freeze}, 32'd0);
      chk("rstmid_addr", bus.final_address, 32'h0);
      chk("rstmid_instr", bus.instr_out, 32'h00000013);
      #1 rst = 1'b0;
      tick();
      bus.d_ack = 1'b1; bus.memload = 32'hFFFF_FFFF;
      tick(); bus.d_ack = 1'b0; #1;
      chk("idle_ack_ignored_load", bus.load_data, 32'h0);
      chk("idle_ack_mem_read", {31'b0, bus.mem_read}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
